sar_adc_ctrl_nb: RTL
====================

Name: sar_adc_ctrl_nb

Overview:
- Parametrised, fully synchronous successor to the 10-bit SAR conversion FSM.
- Runs an N-bit successive-approximation conversion against an external comparator using a 4-phase fire_comp/comp_done handshake.
- Supports a calibration conversion that measures comparator offset and stores it. All later results are offset-corrected with saturation.
- Optionally averages 2^AVG_LOG2 back-to-back conversions per start request.
- Sits between the sample/hold + DAC front end and the comparator, in place of the ripple-clocked FSM.

Parameters:
- WIDTH, 10, conversion resolution in bits (legal 4..16).
- AVG_LOG2, 0, log2 of the number of conversions averaged per st_conv (legal 0..4).
- SAMPLE_CYC, 2, cycles sample is held high before bit trials start (legal ≥1).
- CMP_TIMEOUT, 15, max cycles to wait for a comp_done edge (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- st_conv  in  1  start request. Level sampled each cycle; acted on only in IDLE.
- cal  in  1  sampled together with st_conv. When 1, the run is a calibration.
- sample  out  1  sample/hold track enable.
- dac_value  out  WIDTH  current SAR trial code driven to the DAC.
- fire_comp  out  1  comparator strobe request.
- comp_done  in  1  comparator acknowledge.
- comp_in  in  1  comparator decision: 1 = input ≥ DAC, keep the trial bit.
- result  out  WIDTH  corrected, averaged result; held until the next adc_done.
- adc_done  out  1  one-cycle pulse when result updates.
- busy  out  1  high from accepted start until adc_done.
- offset  out  WIDTH+1  signed stored offset (two's complement).
- cmp_err  out  1  sticky timeout flag; cleared at each accepted start.

Behaviour:
- Reset: all outputs 0. offset cleared to 0. FSM goes to IDLE.
  - Reset mid-conversion aborts immediately: no adc_done, result forced to 0.
- States: IDLE → SAMPLE → FIRE → RELEASE → (FIRE for next bit | ACCUM) → (SAMPLE for next averaged conversion | FINISH) → IDLE.
- IDLE:
  - busy=0, sample=0, dac_value=0.
  - When st_conv=1: latch cal, clear accumulator and cmp_err, set busy=1, go to SAMPLE. st_conv is ignored while busy.
- SAMPLE:
  - sample=1 for exactly SAMPLE_CYC cycles, dac_value=0.
  - Then sample drops to 0, bit index i=WIDTH-1, dac_value has only bit i set, go to FIRE.
- FIRE:
  - fire_comp=1.
  - On the first cycle comp_done=1: register comp_in. If comp_in=0, clear bit i of dac_value. Deassert fire_comp and go to RELEASE.
- RELEASE:
  - Wait for comp_done=0.
  - If i>0: decrement i, set bit i, go to FIRE. If i=0: go to ACCUM.
- ACCUM:
  - Add dac_value into an accumulator of WIDTH+AVG_LOG2 bits.
  - If fewer than 2^AVG_LOG2 conversions are done, go to SAMPLE. Otherwise go to FINISH.
- FINISH: raw = acc >> AVG_LOG2 (truncating).
  - Calibration run: offset = raw − 2^(WIDTH−1) (signed, WIDTH+1 bits). result = raw.
  - Normal run: result = clamp(raw − offset, 0, 2^WIDTH−1).
  - In both cases: adc_done=1 for one cycle, busy=0, return to IDLE. A new st_conv is accepted the cycle after.
- Latency (comparator acking d cycles after fire_comp and releasing 1 cycle after fire_comp drops): per conversion SAMPLE_CYC + WIDTH·(d+2) + 1 cycles. Plus 1 cycle for FINISH.
- comp_done already high on entry to FIRE: accepted on that cycle. The bench must not do this; behaviour is defined but not recommended.

Optional Feature:
- Macro SAR_CMP_TIMEOUT_EN.
- Defined: a counter runs in FIRE and RELEASE. If the awaited comp_done edge has not arrived after CMP_TIMEOUT cycles:
  - FIRE: treat the decision as comp_in=0.
  - RELEASE: treat comp_done as released.
  - In both cases set cmp_err=1 and proceed.
- Undefined: no counter. FIRE/RELEASE wait indefinitely. cmp_err is tied to 0.

Test Plan:
1. Reset then idle: rst for 2 cycles → all outputs 0, offset=0. No adc_done for 50 cycles with st_conv=0.
2. WIDTH=10, ideal comparator (comp_in = vin ≥ dac_value, d=2), vin=512, no cal → result=512, one adc_done, busy high for 2+10·4+2=44 cycles. Sweep vin=0 and 1023 → result 0 and 1023.
3. Comparator model offset +100 (compares vin ≥ dac+100):
   - cal run with vin=512 → raw 412, offset=−100.
   - Then vin=300 → result=300.
4. After step 3, switch model offset to 0 and convert vin=1000 → raw 1000, corrected 1100 clamped → result=1023. Assert st_conv during busy → ignored, single adc_done.
5. AVG_LOG2=2, comparator model returns codes 510, 511, 512, 513 on successive conversions → result=511. Exactly one adc_done after 4 conversions.
6. With SAR_CMP_TIMEOUT_EN and CMP_TIMEOUT=8, comparator never acks → result=0, cmp_err=1, adc_done still pulses. Separately, rst asserted mid-FIRE → IDLE next cycle, no adc_done.

Source files
------------

// File: rtl/sar_adc_ctrl_nb.sv
// rtl/sar_adc_ctrl_nb.sv - offset-calibrated, averaging SAR ADC conversion controller
//
// Runs an N-bit successive-approximation conversion against an external
// comparator using a 4-phase fire_comp/comp_done handshake. A calibration run
// stores the comparator offset. Later results are offset-corrected and
// saturated. 2^AVG_LOG2 conversions are averaged per start request.
//
// Optional feature macro: SAR_CMP_TIMEOUT_EN (comparator handshake timeout, cmp_err)
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   st_conv    start request, acted on only in IDLE
//   cal        sampled with st_conv; 1 = calibration run
//   sample     sample/hold track enable
//   dac_value  current SAR trial code to the DAC
//   fire_comp  comparator strobe request
//   comp_done  comparator acknowledge
//   comp_in    comparator decision, 1 = keep trial bit
//   result     corrected, averaged result, held until next adc_done
//   adc_done   one-cycle pulse when result updates
//   busy       high from accepted start until adc_done
//   offset     signed stored comparator offset (WIDTH+1 bits)
//   cmp_err    sticky handshake timeout flag, cleared at each accepted start
module sar_adc_ctrl_nb #(
   parameter int WIDTH       = 10,
   parameter int AVG_LOG2    = 0,
   parameter int SAMPLE_CYC  = 2,
   parameter int CMP_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_conv,
   input  logic             cal,
   output logic             sample,
   output logic [WIDTH-1:0] dac_value,
   output logic             fire_comp,
   input  logic             comp_done,
   input  logic             comp_in,
   output logic [WIDTH-1:0] result,
   output logic             adc_done,
   output logic             busy,
   output logic [WIDTH:0]   offset,
   output logic             cmp_err
);

   localparam int AW = WIDTH + AVG_LOG2;
   localparam int IW = $clog2(WIDTH);
   localparam int SW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0]  LAST_CONV = CW'((1 << AVG_LOG2) - 1);
   localparam logic [WIDTH:0] MID_CODE  = (WIDTH+1)'(1) << (WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SAMPLE, S_FIRE, S_RELEASE, S_ACCUM, S_FINISH
   } state_t;

   state_t                   state, state_nxt;
   logic [SW-1:0]            samp_cnt;
   logic [IW-1:0]            bit_idx;
   logic [AW-1:0]            acc;
   logic [CW-1:0]            conv_cnt;
   logic                     cal_run;
   logic                     tmo_hit;
   logic                     start, samp_last, fire_go, rel_go;
   logic [WIDTH-1:0]         raw;
   logic signed [WIDTH+1:0]  corr;
   logic [WIDTH-1:0]         corr_sat;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      fire_comp = 1'b0;
      busy      = 1'b1;
      start     = 1'b0;
      samp_last = 1'b0;
      fire_go   = 1'b0;
      rel_go    = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (st_conv) begin
               start     = 1'b1;
               state_nxt = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            sample = 1'b1;
            if (samp_cnt == SW'(SAMPLE_CYC - 1)) begin
               samp_last = 1'b1;
               state_nxt = S_FIRE;
            end
         end
         S_FIRE: begin
            fire_comp = 1'b1;
            if (comp_done || tmo_hit) begin
               fire_go   = 1'b1;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!comp_done || tmo_hit) begin
               rel_go    = 1'b1;
               state_nxt = (bit_idx == '0) ? S_ACCUM : S_FIRE;
            end
         end
         S_ACCUM:  state_nxt = (conv_cnt == LAST_CONV) ? S_FINISH : S_SAMPLE;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Truncating average, then offset correction clamped to the code range.
   assign raw = acc[AW-1:AVG_LOG2];
   assign corr = $signed({2'b00, raw}) - $signed({offset[WIDTH], offset});

   always_comb begin
      corr_sat = corr[WIDTH-1:0];
      if (corr[WIDTH+1])  corr_sat = '0;
      else if (corr[WIDTH]) corr_sat = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dac_value <= '0;
         samp_cnt  <= '0;
         bit_idx   <= '0;
         acc       <= '0;
         conv_cnt  <= '0;
         cal_run   <= 1'b0;
         result    <= '0;
         adc_done  <= 1'b0;
         offset    <= '0;
      end else begin
         adc_done <= 1'b0;
         case (state)
            S_IDLE: begin
               dac_value <= '0;
               samp_cnt  <= '0;
               if (start) begin
                  cal_run  <= cal;
                  acc      <= '0;
                  conv_cnt <= '0;
               end
            end
            S_SAMPLE: begin
               if (samp_last) begin
                  samp_cnt  <= '0;
                  bit_idx   <= IW'(WIDTH - 1);
                  dac_value <= {1'b1, {(WIDTH-1){1'b0}}};
               end else begin
                  samp_cnt <= samp_cnt + 1'b1;
               end
            end
            S_FIRE: begin
               // A timeout without an ack counts as comp_in = 0.
               if (fire_go && !(comp_done && comp_in)) dac_value[bit_idx] <= 1'b0;
            end
            S_RELEASE: begin
               if (rel_go && bit_idx != '0) begin
                  bit_idx                       <= bit_idx - 1'b1;
                  dac_value[bit_idx - 1'b1]     <= 1'b1;
               end
            end
            S_ACCUM: begin
               acc       <= acc + AW'(dac_value);
               conv_cnt  <= conv_cnt + 1'b1;
               dac_value <= '0;
            end
            S_FINISH: begin
               adc_done <= 1'b1;
               if (cal_run) begin
                  offset <= {1'b0, raw} - MID_CODE;
                  result <= raw;
               end else begin
                  result <= corr_sat;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SAR_CMP_TIMEOUT_EN
   localparam int TW = $clog2(CMP_TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;

   // Restarts on every state change so FIRE and RELEASE each get a full window.
   always_ff @(posedge clk) begin
      if (rst || state_nxt != state)                 tmo_cnt <= '0;
      else if (state == S_FIRE || state == S_RELEASE) tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (state == S_FIRE || state == S_RELEASE) &&
                    (tmo_cnt == TW'(CMP_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || start) begin
         cmp_err <= 1'b0;
      end else if (tmo_hit && ((state == S_FIRE && !comp_done) ||
                               (state == S_RELEASE && comp_done))) begin
         cmp_err <= 1'b1;
      end
   end
`else
   // No timeout: FIRE and RELEASE wait for the comparator indefinitely.
   assign tmo_hit = 1'b0 & (CMP_TIMEOUT > 0);
   assign cmp_err = 1'b0;
`endif

endmodule
